// File: rtl/onehot_rotation_checker.sv
// ---------------------------------------------------------------------------
// onehot_rotation_checker
//
// Watches the rotating one-hot LED pattern of the LED rotation shift register
// and confirms it advances exactly one position per valid strobe. The checker
// hunts for a one-hot pattern, locks onto it, and from then on predicts the
// next pattern itself. Any cycle where the observed pattern differs from the
// prediction is a mismatch: it is flagged, counted and forces a new hunt.
//
// Parameters:
//   NB_LED    width of the monitored one-hot pattern (>= 2)
//   NB_COUNT  width of the rotation and error counters
//
// Ports:
//   clock        system clock, all logic on the rising edge
//   i_reset      synchronous, active-low reset
//   i_led        pattern under check (shift register output)
//   i_valid      advance strobe shared with the shift register
//   o_locked     checker is tracking a valid one-hot pattern
//   o_position   index of the lit bit of the expected pattern
//   o_error      sticky mismatch flag, cleared only by reset
//   o_err_count  mismatch events, saturating at all-ones
//   o_rot_count  completed rotations (MSB->LSB wraps), wraps around
//
// All outputs come from registers or from decode of registers only; there is
// no combinational path from i_led or i_valid to any output.
// ---------------------------------------------------------------------------
module onehot_rotation_checker #(
  parameter int NB_LED   = 4,
  parameter int NB_COUNT = 8
) (
  input  logic                      clock,
  input  logic                      i_reset,
  input  logic [NB_LED-1:0]         i_led,
  input  logic                      i_valid,
  output logic                      o_locked,
  output logic [$clog2(NB_LED)-1:0] o_position,
  output logic                      o_error,
  output logic [NB_COUNT-1:0]       o_err_count,
  output logic [NB_COUNT-1:0]       o_rot_count
);

  localparam int NB_POS = $clog2(NB_LED);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [NB_LED-1:0]   r_expect;
  logic [NB_LED-1:0]   w_expect_next;
  logic                r_error;
  logic [NB_COUNT-1:0] r_err_count;
  logic [NB_COUNT-1:0] r_rot_count;
  logic                w_led_onehot;
  logic                w_mismatch;
  logic                w_rotation_done;
  logic [NB_POS-1:0]   w_position;

  // Rotate left by one: the MSB wraps around into bit 0.
  function automatic logic [NB_LED-1:0] rotl(input logic [NB_LED-1:0] x);
    return {x[NB_LED-2:0], x[NB_LED-1]};
  endfunction

  // Exactly one bit set: non-zero, and clearing the lowest set bit leaves zero.
  assign w_led_onehot = (i_led != '0) && ((i_led & (i_led - NB_LED'(1))) == '0);

  // ---------------------------------------------------------------------------
  // Next-state / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    w_state_next    = r_state;
    w_expect_next   = r_expect;
    w_mismatch      = 1'b0;
    w_rotation_done = 1'b0;

    case (r_state)
      HUNT: begin
        // Zero or multi-hot patterns are simply ignored while hunting.
        if (w_led_onehot) begin
          // The shift register advances at the same edge that samples i_valid,
          // so the prediction for next cycle must already be rotated.
          w_expect_next = i_valid ? rotl(i_led) : i_led;
          w_state_next  = LOCKED;
        end
      end
      LOCKED: begin
        if (i_led != r_expect) begin
          // Mismatch wins over i_valid: the prediction is frozen and rehunted.
          w_mismatch   = 1'b1;
          w_state_next = HUNT;
        end else if (i_valid) begin
          w_expect_next   = rotl(r_expect);
          w_rotation_done = r_expect[NB_LED-1];
        end
      end
      default: w_state_next = HUNT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      r_state     <= HUNT;
      r_expect    <= '0;
      r_error     <= 1'b0;
      r_err_count <= '0;
      r_rot_count <= '0;
    end else begin
      r_state  <= w_state_next;
      r_expect <= w_expect_next;

      if (w_mismatch) begin
        r_error <= 1'b1;
        if (r_err_count != '1) begin
          r_err_count <= r_err_count + NB_COUNT'(1);
        end
      end

      if (w_rotation_done) begin
        r_rot_count <= r_rot_count + NB_COUNT'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Position decode from the predicted pattern (0 when nothing is predicted)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_position = '0;
    for (int i = 0; i < NB_LED; i++) begin
      if (r_expect[i]) begin
        w_position = NB_POS'(i);
      end
    end
  end

  assign o_locked    = (r_state == LOCKED);
  assign o_position  = w_position;
  assign o_error     = r_error;
  assign o_err_count = r_err_count;
  assign o_rot_count = r_rot_count;

endmodule

// File: doc/onehot_rotation_checker.md
# onehot_rotation_checker

Monitors the 4-bit rotating one-hot LED pattern produced by the team's LED rotation shift register and confirms that it advances exactly one position per valid strobe. It sits beside the shift register, receives the same valid strobe and the register's LED output, and locks onto the pattern. Once locked it reports the current lit position, counts full rotations, and flags and counts any step that does not match the expected pattern.

## Interface
Parameters:
- NB_LED, 4, width of the monitored one-hot pattern (≥2)
- NB_COUNT, 8, width of rotation and error counters

Ports:
- clock  input  1  system clock, all logic on rising edge
- i_reset  input  1  synchronous, active-low reset
- i_led  input  NB_LED  pattern under check (shift register output)
- i_valid  input  1  same advance strobe that drives the shift register
- o_locked  output  1  checker is tracking a valid one-hot pattern
- o_position  output  $clog2(NB_LED)  index of the lit bit of the expected pattern
- o_error  output  1  sticky mismatch flag
- o_err_count  output  NB_COUNT  mismatch events, saturating
- o_rot_count  output  NB_COUNT  completed rotations (MSB→LSB wraps), wraps modulo 2^NB_COUNT

## Operation
- Internal state: r_expect[NB_LED-1:0] and a 2-state FSM, HUNT and LOCKED.
- rotl(x) = {x[NB_LED-2:0], x[NB_LED-1]}.
- Reset (i_reset=0 at a rising edge): FSM goes to HUNT. r_expect, o_locked, o_error, o_err_count and o_rot_count all clear to 0. Reset overrides every other input.
- HUNT:
  - If i_led is one-hot: load r_expect with i_valid ? rotl(i_led) : i_led, then go to LOCKED.
  - If i_led is zero or has more than one bit set: stay in HUNT. No error is counted.
- LOCKED, i_led == r_expect:
  - If i_valid=1: r_expect is loaded with rotl(r_expect).
  - If i_valid=1 and r_expect[NB_LED-1]=1: o_rot_count increments.
- LOCKED, i_led != r_expect:
  - o_error is set and o_err_count increments, saturating at all-ones.
  - FSM goes to HUNT. r_expect is unchanged.
  - Mismatch takes priority over i_valid: no rotation and no rotation count in that cycle.
- o_locked = (FSM == LOCKED).
- o_position = binary index of the set bit in r_expect; 0 when r_expect == 0.
- o_error clears only on reset.

## Timing
- The shift register updates i_led at the edge where it samples i_valid=1. r_expect rotates at the same edge, so the comparison in the next cycle needs no extra latency.
- Lock latency: a one-hot i_led sampled in HUNT gives o_locked=1 one cycle later.
- Mismatch to o_error=1, o_err_count+1 and o_locked=0: one cycle.
- Relock after a mismatch: the earliest is the edge after the first HUNT cycle that sees a one-hot i_led. The minimum mismatch-to-relocked time is 2 cycles.
- i_valid asserted every cycle is supported: one step per cycle with no bubbles.
- i_valid held low: r_expect is held and comparison continues every cycle.
- Reset mid-rotation: all outputs read 0 one cycle after the reset edge. Relock follows normal HUNT rules once i_reset=1.
- All outputs are registered or decoded only from registers. There is no combinational path from i_led or i_valid to any output.

## Test plan
All scenarios use NB_LED=4, NB_COUNT=8 unless stated otherwise.
- Reset: hold i_reset=0 for 2 cycles with i_led=0001 and i_valid=1.
  - Required: o_locked=0, o_position=0, o_error=0, both counts 0.
- Lock: release reset with i_led=0001 and i_valid=0.
  - Required: o_locked=1 next cycle, o_position=0, o_error=0.
- Rotation: drive a shift-register model with i_valid=1 on 8 consecutive cycles starting from 0001.
  - Required: o_position steps 1,2,3,0,1,2,3,0.
  - Required: o_rot_count=2, o_err_count=0, o_locked stays 1.
- Corruption: while locked on 0100, force i_led=0110 for one cycle, then restore the correct pattern.
  - Required next cycle: o_error=1, o_err_count=1, o_locked=0.
  - Required: o_locked=1 two cycles after the fault; o_error stays 1.
- Invalid patterns: in HUNT, drive i_led=0000 for 10 cycles, then 1010 for 5 cycles.
  - Required: o_locked=0 throughout, o_err_count=0.
- Saturation and reset mid-operation, NB_COUNT=2: cause 5 mismatch events.
  - Required: o_err_count=3 (saturated).
  - Then assert i_reset=0 for one cycle. Required next cycle: all outputs 0.
